// File: rtl/div_freq_en_multi.sv
`timescale 1ns/1ps
// Multi-channel clock-enable generator: per-channel programmable divider, continuous or one-shot.
// Optional global counter restart is compiled in when DIV_FREQ_EN_ALIGN_EN is defined.
module div_freq_en_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 1000,
  parameter int INIT        = 0,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK_IN,
  input  logic                RST_N,
  input  logic                WR,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [CNT_W-1:0]    WR_DIV,
  input  logic                WR_MODE,
  input  logic [CHANNELS-1:0] RUN,
  input  logic [CHANNELS-1:0] TRIG,
  input  logic                ALIGN,
  output logic [CHANNELS-1:0] ENABLE,
  output logic [CHANNELS-1:0] BUSY,
  output logic                WR_ERR
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("div_freq_en_multi: CHANNELS must be in 1..16");
  end
  if (DIV_DEFAULT < 1 || (CNT_W < 31 && DIV_DEFAULT >= (1 << CNT_W))) begin : g_bad_div
    $error("div_freq_en_multi: DIV_DEFAULT must be in 1..2^CNT_W-1");
  end
  if (INIT < 0 || INIT >= DIV_DEFAULT) begin : g_bad_init
    $error("div_freq_en_multi: INIT must be below DIV_DEFAULT");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic wr_in_range;
  logic wr_valid;
  logic align_req;
  logic wr_err_reg;

  assign wr_in_range = ({1'b0, WR_CH} < CH_LIMIT);
  assign wr_valid    = WR && wr_in_range;

`ifdef DIV_FREQ_EN_ALIGN_EN
  assign align_req = ALIGN;
`else
  logic unused_align;
  assign unused_align = ALIGN;
  assign align_req    = 1'b0;
`endif

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      wr_err_reg <= 1'b0;
    end else if (WR && !wr_in_range) begin
      wr_err_reg <= 1'b1;
    end
  end

  assign WR_ERR = wr_err_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             enable_reg, enable_next;
    state_t           state_reg, state_next;
    logic             wr_hit;
    logic             parked;
    logic             terminal;

    assign wr_hit   = wr_valid && (WR_CH == CH_W'(gi));
    assign parked   = (div_reg == '0);
    assign terminal = (cnt_reg == div_reg - CNT_W'(1));

    always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
        state_reg  <= ST_IDLE;
        div_reg    <= CNT_W'(DIV_DEFAULT);
        cnt_reg    <= CNT_W'(INIT);
        mode_reg   <= 1'b0;
        enable_reg <= 1'b0;
      end else begin
        state_reg  <= state_next;
        div_reg    <= div_next;
        cnt_reg    <= cnt_next;
        mode_reg   <= mode_next;
        enable_reg <= enable_next;
      end
    end

    // One-shot sequencing; writes, restarts and parked or continuous channels sit in IDLE.
    always_comb begin
      state_next = state_reg;
      if (wr_hit || align_req || parked || !mode_reg) begin
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE:  if (TRIG[gi]) state_next = ST_COUNT;
          ST_COUNT: if (terminal) state_next = ST_IDLE;
          default:  state_next = ST_IDLE;
        endcase
      end
    end

    always_comb begin
      div_next    = div_reg;
      mode_next   = mode_reg;
      cnt_next    = cnt_reg;
      enable_next = 1'b0;
      if (wr_hit) begin
        div_next  = WR_DIV;
        mode_next = WR_MODE;
        cnt_next  = '0;
      end else if (align_req || parked) begin
        cnt_next = '0;
      end else if (!mode_reg) begin
        if (RUN[gi]) begin
          if (terminal) begin
            cnt_next    = '0;
            enable_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end else begin
        case (state_reg)
          ST_COUNT: begin
            if (terminal) begin
              cnt_next    = '0;
              enable_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: cnt_next = '0;
        endcase
      end
    end

    assign ENABLE[gi] = enable_reg;
    assign BUSY[gi]   = (state_reg == ST_COUNT);
  end

endmodule

// File: doc/div_freq_en_multi.md
# div_freq_en_multi

Multi-channel clock-enable generator: CHANNELS independent counters on one clock, each producing a one-cycle ENABLE strobe at a runtime-programmable division ratio. Each channel runs either continuously or as a triggered one-shot. No derived clocks are produced and no global buffers are consumed. It sits beside the peripheral controllers (I2C, UART, timers) and supplies their bit-rate and tick enables from the single system clock.

## Interface

Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- CNT_W, 16: width of the divisor and counter per channel.
- DIV_DEFAULT, 1000: divisor loaded into every channel at reset (1..2^CNT_W-1).
- INIT, 0: counter reset value. Must be < DIV_DEFAULT; violation is an elaboration error.

Ports:
- CLK_IN  in  1  single clock. All logic is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WR  in  1  configuration write strobe, one cycle.
- WR_CH  in  max(1,$clog2(CHANNELS))  target channel of the write.
- WR_DIV  in  CNT_W  new divisor.
- WR_MODE  in  1  0 = continuous, 1 = one-shot.
- RUN  in  CHANNELS  per-channel run gate (continuous mode).
- TRIG  in  CHANNELS  per-channel start (one-shot mode), level-sampled.
- ALIGN  in  1  restart all counters together (see Configuration).
- ENABLE  out  CHANNELS  registered one-cycle enable strobes.
- BUSY  out  CHANNELS  one-shot in progress.
- WR_ERR  out  1  sticky: a write addressed a nonexistent channel.

## Operation

Per-channel state: divisor D, mode bit M, counter C. Reset values: D = DIV_DEFAULT, M = 0, C = INIT, ENABLE = 0, BUSY = 0, WR_ERR = 0.

- Continuous (M=0), RUN[i]=1:
  - If C == D-1: C <= 0, ENABLE[i] <= 1.
  - Else: C <= C+1, ENABLE[i] <= 0.
- Continuous, RUN[i]=0: C holds, ENABLE[i] <= 0.
- One-shot (M=1), two states IDLE/COUNT:
  - IDLE: BUSY=0, C=0. TRIG[i]=1 moves to COUNT with BUSY <= 1.
  - COUNT: C increments. At C == D-1, ENABLE[i] <= 1, BUSY <= 0 and C <= 0 on the same edge, returning to IDLE. TRIG is ignored in COUNT.
  - A TRIG held high re-arms on the cycle after return to IDLE, giving a period of D+1.
- D=0: channel is parked. C held at 0, ENABLE 0, BUSY 0, RUN and TRIG ignored.
- D=1: continuous mode gives ENABLE high every cycle while RUN=1.
- Write, when WR=1 and WR_CH < CHANNELS:
  - On that edge, D <= WR_DIV, M <= WR_MODE, C <= 0, ENABLE <= 0, BUSY <= 0.
  - The new setting counts from the next cycle.
- Write, when WR=1 and WR_CH >= CHANNELS: the write is ignored and WR_ERR <= 1. WR_ERR clears only on reset.
- Simultaneous events:
  - Write and terminal count on the same channel: the write wins and no strobe is issued.
  - Write and ALIGN together: the write applies, and all counters go to 0.
  - TRIG and a write in the same cycle: the write wins and the channel stays IDLE.
- Counter arithmetic is CNT_W-bit unsigned. C never exceeds D-1, so it does not wrap.
- Reset asserted mid-count: all state returns to reset values asynchronously. INIT applies only after reset; writes and ALIGN always clear C to 0.

## Timing

- Continuous mode, RUN=1 from reset release, INIT=0: ENABLE is high in the cycle after rising edges D, 2D, 3D, ... Period is exactly D cycles, duty 1/D.
- Non-zero INIT: the first strobe follows edge D-INIT.
- RUN rising: counting resumes on the first edge with RUN=1. RUN falling: ENABLE is 0 on the next edge.
- One-shot latency: TRIG sampled on edge t gives ENABLE high after edge t+D, and BUSY falls after that same edge t+D.
- Write latency: the first strobe after a write on edge t follows edge t+D_new, provided the channel is running or triggered.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration

- DIV_FREQ_EN_ALIGN_EN defined:
  - ALIGN=1 on an edge sets C <= 0 and ENABLE <= 0 in every channel.
  - One-shot channels abort to IDLE with BUSY <= 0.
  - Channels with equal or harmonically related D are phase-aligned from then on.
- Not defined: the ALIGN port exists but is ignored, and no align logic is synthesised.

## Test plan

- Reset release, RUN=4'b0001, D0=1000 (default) -> ENABLE[0] pulses after edges 1000, 2000, 3000; ENABLE[3:1] stay 0, BUSY=0.
- Write ch1 D=5 M=0 on edge t, RUN[1]=1 -> ENABLE[1] after edges t+5, t+10; a write of D=3 on edge t+7 gives next pulses after t+10 and t+13, where t+10 is 3 after t+7.
- Write ch2 D=4 M=1, then TRIG[2] one cycle on edge s -> BUSY[2] high after edges s..s+3, ENABLE[2] single pulse after edge s+4; TRIG at s+2 ignored.
- Write ch0 D=0 -> ENABLE[0]=0 for 100 cycles with RUN=1; write WR_CH=7 with CHANNELS=4 -> WR_ERR=1, all D unchanged, WR_ERR stays 1 until RST_N low.
- Defined ALIGN_EN, ch0 D=4, ch1 D=8, random skew, ALIGN pulse at edge a -> both strobe after a+8, a+16; ENABLE[0] also after a+4, a+12.
- RST_N low mid-count, asynchronous with no clock edge -> ENABLE, BUSY and WR_ERR read 0 immediately; after release all channels are back at D=DIV_DEFAULT.
